// File: rtl/layer_out_serializer.sv
// layer_out_serializer
// Captures NUM_CH x CH_W layer-output vectors into a small FIFO and streams the
// enabled channels out as OUT_W-bit valid/ready beats: channels in ascending
// index order, LSB slice first, with out_last on the final beat of each vector.
module layer_out_serializer #(
  parameter int NUM_CH = 2,
  parameter int CH_W   = 128,
  parameter int OUT_W  = 32,
  parameter int DEPTH  = 4,
  parameter int CW     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [NUM_CH*CH_W-1:0]   in_data,
  input  logic [NUM_CH-1:0]        ch_mask,
  output logic                     in_ready,
  output logic                     out_valid,
  output logic [OUT_W-1:0]         out_data,
  output logic [CW-1:0]            out_ch,
  output logic                     out_last,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     overflow,
  output logic [31:0]              beat_cnt,
  input  logic                     clr_status
);

  localparam int SLICES = CH_W / OUT_W;
  localparam int SW     = (SLICES > 1) ? $clog2(SLICES) : 1;
  localparam int AW     = $clog2(DEPTH);
  localparam int DW     = NUM_CH * CH_W;
  localparam int EW     = NUM_CH + DW;
  localparam logic [SW-1:0] LAST_SLICE = SW'(SLICES - 1);
  localparam logic [AW:0]   DEPTH_V    = (AW + 1)'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_SEND  = 2'd2
  } state_t;

  // Lowest enabled channel at or above index 'from' (0 when none remain).
  function automatic logic [CW-1:0] first_ch(input logic [NUM_CH-1:0] m, input int from);
    logic [CW-1:0] r;
    logic          found;
    r     = {CW{1'b0}};
    found = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (!found && (k >= from) && m[k]) begin
        r     = CW'(k);
        found = 1'b1;
      end
    end
    return r;
  endfunction

  // Highest enabled channel; its last slice closes the entry.
  function automatic logic [CW-1:0] last_ch(input logic [NUM_CH-1:0] m);
    logic [CW-1:0] r;
    r = {CW{1'b0}};
    for (int k = 0; k < NUM_CH; k++) begin
      if (m[k]) begin
        r = CW'(k);
      end
    end
    return r;
  endfunction

  // One OUT_W slice of a stored vector.
  function automatic logic [OUT_W-1:0] pick_beat(input logic [DW-1:0] d,
                                                 input logic [CW-1:0] c,
                                                 input logic [SW-1:0] s);
    return d[int'(c) * CH_W + int'(s) * OUT_W +: OUT_W];
  endfunction

  logic [EW-1:0]     mem_r [DEPTH];
  logic [AW-1:0]     wr_ptr_r;
  logic [AW-1:0]     rd_ptr_r;
  logic [AW:0]       count_r;
  state_t            state_r;
  logic [DW-1:0]     ent_data_r;
  logic [NUM_CH-1:0] ent_mask_r;
  logic [CW-1:0]     ch_r;
  logic [SW-1:0]     slice_r;

  logic              push_s;
  logic              pop_s;
  logic              fire_s;
  logic [DW-1:0]     head_data_s;
  logic [NUM_CH-1:0] head_mask_s;
  logic [CW-1:0]     head_first_s;
  logic              head_last_s;
  logic [OUT_W-1:0]  head_beat_s;
  logic [CW-1:0]     adv_ch_s;
  logic [SW-1:0]     adv_slice_s;
  logic              adv_last_s;
  logic [OUT_W-1:0]  adv_beat_s;

  assign in_ready   = (count_r < DEPTH_V);
  assign fifo_count = count_r;

  // Handshake qualifiers and FIFO pop decision.
  always_comb begin
    fire_s = out_valid && out_ready;
    push_s = in_valid && in_ready && (ch_mask != {NUM_CH{1'b0}});
    if (count_r == {(AW + 1){1'b0}}) begin
      pop_s = 1'b0;
    end else if (state_r == ST_IDLE) begin
      pop_s = 1'b1;
    end else if ((state_r == ST_SEND) && fire_s && out_last) begin
      pop_s = 1'b1;
    end else begin
      pop_s = 1'b0;
    end
  end

  // First beat of the FIFO head entry, used whenever an entry is loaded.
  always_comb begin
    {head_mask_s, head_data_s} = mem_r[rd_ptr_r];
    head_first_s = first_ch(head_mask_s, 0);
    head_last_s  = (LAST_SLICE == {SW{1'b0}}) && (head_first_s == last_ch(head_mask_s));
    head_beat_s  = pick_beat(head_data_s, head_first_s, {SW{1'b0}});
  end

  // Next beat within the current entry: next slice, or first slice of the next enabled channel.
  always_comb begin
    if (slice_r == LAST_SLICE) begin
      adv_ch_s    = first_ch(ent_mask_r, int'(ch_r) + 1);
      adv_slice_s = {SW{1'b0}};
    end else begin
      adv_ch_s    = ch_r;
      adv_slice_s = slice_r + 1'b1;
    end
    adv_last_s = (adv_slice_s == LAST_SLICE) && (adv_ch_s == last_ch(ent_mask_r));
    adv_beat_s = pick_beat(ent_data_r, adv_ch_s, adv_slice_s);
  end

  // FIFO storage; contents need no reset because pointers define validity.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= {ch_mask, in_data};
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {(AW + 1){1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + 1'b1;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + 1'b1;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + 1'b1;
        2'b01:   count_r <= count_r - 1'b1;
        default: count_r <= count_r;
      endcase
    end
  end

  // Sticky overflow flag (a new overflow beats a clear) and downstream beat counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow <= 1'b0;
      beat_cnt <= 32'd0;
    end else begin
      if (in_valid && !in_ready) begin
        overflow <= 1'b1;
      end else if (clr_status) begin
        overflow <= 1'b0;
      end
      if (clr_status) begin
        beat_cnt <= 32'd0;
      end else if (fire_s) begin
        beat_cnt <= beat_cnt + 32'd1;
      end
    end
  end

  // Output sequencer: load an entry, present it a cycle later, then walk its beats.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      ent_data_r <= {DW{1'b0}};
      ent_mask_r <= {NUM_CH{1'b0}};
      ch_r       <= {CW{1'b0}};
      slice_r    <= {SW{1'b0}};
      out_valid  <= 1'b0;
      out_data   <= {OUT_W{1'b0}};
      out_ch     <= {CW{1'b0}};
      out_last   <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (pop_s) begin
            ent_data_r <= head_data_s;
            ent_mask_r <= head_mask_s;
            ch_r       <= head_first_s;
            slice_r    <= {SW{1'b0}};
            out_data   <= head_beat_s;
            out_ch     <= head_first_s;
            out_last   <= head_last_s;
            state_r    <= ST_PRIME;
          end
        end
        ST_PRIME: begin
          out_valid <= 1'b1;
          state_r   <= ST_SEND;
        end
        ST_SEND: begin
          if (fire_s) begin
            if (out_last) begin
              if (pop_s) begin
                // Back-to-back entry: out_valid stays high, no bubble.
                ent_data_r <= head_data_s;
                ent_mask_r <= head_mask_s;
                ch_r       <= head_first_s;
                slice_r    <= {SW{1'b0}};
                out_data   <= head_beat_s;
                out_ch     <= head_first_s;
                out_last   <= head_last_s;
              end else begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
                state_r   <= ST_IDLE;
              end
            end else begin
              ch_r     <= adv_ch_s;
              slice_r  <= adv_slice_s;
              out_data <= adv_beat_s;
              out_ch   <= adv_ch_s;
              out_last <= adv_last_s;
            end
          end
        end
        default: begin
          state_r   <= ST_IDLE;
          out_valid <= 1'b0;
          out_last  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_layer_out_serializer.sv
// Bench for layer_out_serializer: table of directed vectors, hand-written
// corner sequences, and a randomized run against a queue-based beat model.
module tb_layer_out_serializer;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic [255:0] in_data = 256'd0;
  logic [1:0]   ch_mask = 2'b00;
  logic         in_ready;
  logic         out_valid;
  logic [31:0]  out_data;
  logic [0:0]   out_ch;
  logic         out_last;
  logic         out_ready = 1'b0;
  logic [2:0]   fifo_count;
  logic         overflow;
  logic [31:0]  beat_cnt;
  logic         clr_status = 1'b0;

  layer_out_serializer dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .ch_mask(ch_mask),
    .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data), .out_ch(out_ch),
    .out_last(out_last), .out_ready(out_ready), .fifo_count(fifo_count),
    .overflow(overflow), .beat_cnt(beat_cnt), .clr_status(clr_status)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] d;
    logic        ch;
    logic        last;
  } beat_t;

  typedef struct {
    logic [1:0]   mask;
    logic [127:0] c0;
    logic [127:0] c1;
    int           n;
    logic [31:0]  f_d;
    logic         f_ch;
    logic [31:0]  l_d;
    logic         l_ch;
    int           lat;
  } vec_t;

  beat_t       got_q[$];
  beat_t       exp_q[$];
  beat_t       held;
  logic        stall_prev = 1'b0;
  logic        exp_ovf = 1'b0;
  logic [31:0] exp_bc = 32'd0;
  int          n_vec = 0;
  int          n_err = 0;
  vec_t        tbl[6];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Reference: each accepted vector yields its enabled channels in ascending
  // order, four 32-bit slices each, LSB first; last beat = slice 3 of top channel.
  task automatic model_push(input logic [255:0] d, input logic [1:0] m);
    beat_t b;
    int    top;
    top = m[1] ? 1 : 0;
    for (int c = 0; c < 2; c++) begin
      if (m[c]) begin
        for (int s = 0; s < 4; s++) begin
          b.d    = d[c*128 + s*32 +: 32];
          b.ch   = (c == 1);
          b.last = (s == 3) && (c == top);
          exp_q.push_back(b);
        end
      end
    end
  endtask

  // One clock: observe the handshake just before the edge, update the model, advance.
  task automatic cycle();
    beat_t cur;
    cur.d = out_data;
    cur.ch = out_ch[0];
    cur.last = out_last;
    if (stall_prev) begin
      chk("hold_valid", out_valid, 1'b1);
      chk("hold_beat", cur, held);
    end
    if (out_valid && out_ready) got_q.push_back(cur);
    if (in_valid && in_ready && (ch_mask != 2'b00)) model_push(in_data, ch_mask);
    if (in_valid && !in_ready) exp_ovf = 1'b1;
    else if (clr_status) exp_ovf = 1'b0;
    if (clr_status) exp_bc = 32'd0;
    else if (out_valid && out_ready) exp_bc = exp_bc + 32'd1;
    stall_prev = out_valid && !out_ready;
    held = cur;
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  task automatic push(input logic [255:0] d, input logic [1:0] m);
    in_valid = 1'b1;
    in_data  = d;
    ch_mask  = m;
    cycle();
    in_valid = 1'b0;
  endtask

  task automatic compare_stream(input string nm);
    chk({nm, "_len"}, got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) chk(nm, got_q[i], exp_q[i]);
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    logic [127:0] d0, d1, e0, e1;
    logic [5:0]   pat;
    int           lat, nl, run_len;

    d0 = 128'h00000003_00000002_00000001_00000000;
    d1 = 128'h00000007_00000006_00000005_00000004;
    e0 = 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA;
    e1 = 128'h44444444_33333333_22222222_11111111;
    tbl[0] = '{2'b11, d0, d1, 8, 32'h0000_0000, 1'b0, 32'h0000_0007, 1'b1, 2};
    tbl[1] = '{2'b10, d0, d1, 4, 32'h0000_0004, 1'b1, 32'h0000_0007, 1'b1, 2};
    tbl[2] = '{2'b01, d0, d1, 4, 32'h0000_0000, 1'b0, 32'h0000_0003, 1'b0, 2};
    tbl[3] = '{2'b00, d0, d1, 0, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0, 8};
    tbl[4] = '{2'b11, e0, e1, 8, 32'hAAAA_AAAA, 1'b0, 32'h4444_4444, 1'b1, 2};
    tbl[5] = '{2'b01, e0, e1, 4, 32'hAAAA_AAAA, 1'b0, 32'hDDDD_DDDD, 1'b0, 2};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_last", out_last, 1'b0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_out_ch", out_ch, 1'b0);
    chk("rst_fifo_count", fifo_count, 3'd0);
    chk("rst_overflow", overflow, 1'b0);
    chk("rst_beat_cnt", beat_cnt, 32'd0);
    chk("rst_in_ready", in_ready, 1'b1);
    rst = 1'b0;
    run(2);

    // Table-driven single entries with free-flowing output
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      push({tbl[i].c1, tbl[i].c0}, tbl[i].mask);
      lat = 0;
      while (!out_valid && lat < 8) begin
        cycle();
        lat++;
      end
      chk("latency", lat, tbl[i].lat);
      run(12);
      chk("n_beats", got_q.size(), tbl[i].n);
      if (tbl[i].n > 0 && got_q.size() == tbl[i].n) begin
        chk("first_data", got_q[0].d, tbl[i].f_d);
        chk("first_ch", got_q[0].ch, tbl[i].f_ch);
        chk("final_data", got_q[tbl[i].n-1].d, tbl[i].l_d);
        chk("final_ch", got_q[tbl[i].n-1].ch, tbl[i].l_ch);
        chk("final_last", got_q[tbl[i].n-1].last, 1'b1);
      end
      nl = 0;
      foreach (got_q[j]) if (got_q[j].last) nl++;
      chk("n_last", nl, (tbl[i].n > 0) ? 1 : 0);
      chk("fifo_empty", fifo_count, 3'd0);
      chk("in_ready_idle", in_ready, 1'b1);
      chk("beat_cnt", beat_cnt, exp_bc);
      compare_stream("tbl_stream");
    end

    // Backpressure: out_ready 1,0,0,1,0,1 repeating
    pat = 6'b101001;
    push({d1, d0}, 2'b11);
    for (int i = 0; i < 40; i++) begin
      out_ready = pat[i % 6];
      cycle();
    end
    compare_stream("bp_stream");

    // Fill the FIFO with output stalled, overflow, then clear
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) push(rand256(), 2'b11);
    chk("fill4_count", fifo_count, 3'd3);
    chk("fill4_in_ready", in_ready, 1'b1);
    push(rand256(), 2'b11);
    chk("fill5_count", fifo_count, 3'd4);
    chk("fill5_in_ready", in_ready, 1'b0);
    push(rand256(), 2'b11);
    chk("ovf_set", overflow, 1'b1);
    clr_status = 1'b1;
    push(rand256(), 2'b11);
    chk("ovf_set_wins", overflow, 1'b1);
    cycle();
    clr_status = 1'b0;
    chk("ovf_cleared", overflow, 1'b0);
    chk("bc_cleared", beat_cnt, 32'd0);
    out_ready = 1'b1;
    run(60);
    chk("full_beat_cnt", beat_cnt, 32'd40);
    compare_stream("full_stream");

    // Two queued entries stream without a bubble
    push({d1, d0}, 2'b11);
    push({e1, e0}, 2'b11);
    lat = 0;
    while (!out_valid && lat < 8) begin
      cycle();
      lat++;
    end
    chk("b2b_start", out_valid, 1'b1);
    run_len = 0;
    while (out_valid && run_len < 40) begin
      cycle();
      run_len++;
    end
    chk("b2b_run", run_len, 16);
    if (got_q.size() == 16) begin
      chk("b2b_last8", got_q[7].last, 1'b1);
      chk("b2b_last9", got_q[8].last, 1'b0);
      chk("b2b_last16", got_q[15].last, 1'b1);
    end
    compare_stream("b2b_stream");

    // Asynchronous reset in the middle of an entry with two more queued
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) push(rand256(), 2'b11);
    out_ready = 1'b1;
    run(2);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_out_valid", out_valid, 1'b0);
    chk("arst_fifo_count", fifo_count, 3'd0);
    chk("arst_out_last", out_last, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    got_q.delete();
    exp_q.delete();
    exp_bc = 32'd0;
    exp_ovf = 1'b0;
    stall_prev = 1'b0;
    push({e1, e0}, 2'b11);
    run(14);
    chk("post_rst_beat_cnt", beat_cnt, 32'd8);
    compare_stream("post_rst_stream");

    // Randomized traffic against the model
    for (int i = 0; i < 800; i++) begin
      in_valid   = ($urandom % 3) == 0;
      in_data    = rand256();
      ch_mask    = 2'($urandom % 4);
      out_ready  = ($urandom % 10) < 7;
      clr_status = ($urandom % 40) == 0;
      cycle();
      if (i % 100 == 99) begin
        chk("rand_overflow", overflow, exp_ovf);
        chk("rand_beat_cnt", beat_cnt, exp_bc);
      end
    end
    in_valid   = 1'b0;
    clr_status = 1'b0;
    out_ready  = 1'b1;
    run(120);
    chk("rand_end_overflow", overflow, exp_ovf);
    chk("rand_end_beat_cnt", beat_cnt, exp_bc);
    chk("rand_end_fifo", fifo_count, 3'd0);
    compare_stream("rand_stream");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
